// File: rtl/vga_text_fetcher_pkg.sv
// Shared SRAM bus types and VGA text-fetch defaults.
// The fetch FSM state enum and request helpers live here too.
package vga_text_fetcher_pkg;

  localparam int unsigned SRAM_ADDR_WIDTH = 18;
  localparam int unsigned SRAM_DATA_WIDTH = 16;

  typedef struct packed {
    logic [SRAM_ADDR_WIDTH-1:0] address;
    logic [SRAM_DATA_WIDTH-1:0] dout;
    logic                       we_n;
    logic                       oe_n;
    logic                       den;
  } SramRequest_t;

  typedef struct packed {
    logic                       done;
    logic [SRAM_DATA_WIDTH-1:0] din;
  } SramResult_t;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StReq,
    StCapt
  } FetchState_t;

  localparam int unsigned VGA_FETCH_DEPTH     = 16;
  localparam int unsigned VGA_FETCH_MAX_WORDS = 128;

  function automatic SramRequest_t sram_request(input logic                       read,
                                                input logic [SRAM_ADDR_WIDTH-1:0] addr);
    SramRequest_t req;
    req         = '0;
    req.address = addr;
    req.we_n    = 1'b1;
    req.oe_n    = ~read;
    return req;
  endfunction

endpackage

// File: rtl/vga_text_fetcher_if.sv
// SRAM arbiter port seen by the VGA fetcher: read request out, done/data back.
interface vga_text_fetcher_if;
  import vga_text_fetcher_pkg::*;

  SramRequest_t vgaRequest;
  SramResult_t  vgaResult;

  modport master (output vgaRequest, input vgaResult);
  modport slave  (input vgaRequest, output vgaResult);

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous flush and an occupancy count.
// Head word is read straight from the storage registers.
module sync_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             pop_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned CountW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PtrW-1:0]  wr_ptr;
  logic [PtrW-1:0]  rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  always_comb begin
    pop_ok  = pop && (count != '0);
    push_ok = push && ((count != CountW'(DEPTH)) || pop_ok);
  end

  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem    <= '{default: '0};
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PtrW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PtrW'(1);
      end
      if (push_ok && !pop_ok) begin
        count <= count + CountW'(1);
      end else if (pop_ok && !push_ok) begin
        count <= count - CountW'(1);
      end
    end
  end

endmodule

// File: rtl/vga_text_fetcher.sv
// Streams one text row of SRAM words into a FIFO per line_start pulse and
// serves them to the pixel stage over a valid/ready handshake.
module vga_text_fetcher
  import vga_text_fetcher_pkg::*;
#(
  parameter int unsigned DEPTH     = VGA_FETCH_DEPTH,
  parameter int unsigned MAX_WORDS = VGA_FETCH_MAX_WORDS
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               line_start,
  input  logic [SRAM_ADDR_WIDTH-1:0]         line_base,
  input  logic [$clog2(MAX_WORDS+1)-1:0]     line_words,
  vga_text_fetcher_if.master                 sram,
  output logic [SRAM_DATA_WIDTH-1:0]         px_data,
  output logic                               px_valid,
  input  logic                               px_ready,
  output logic                               busy,
  output logic                               underflow
);

  localparam int unsigned WordsW = $clog2(MAX_WORDS + 1);
  localparam int unsigned CountW = $clog2(DEPTH + 1);
  localparam logic [CountW-1:0] LastFree = CountW'(DEPTH - 1);
  localparam logic [CountW-1:0] FullCount = CountW'(DEPTH);

  FetchState_t                state;
  logic [SRAM_ADDR_WIDTH-1:0] cur_addr;
  logic [WordsW-1:0]          remaining;
  logic [CountW-1:0]          fifo_count;
  logic                       push;
  logic                       pop_ok;
  logic                       fills_fifo;

  always_comb begin
    pop_ok     = px_valid && px_ready;
    // A restart in the capture cycle drops the word being returned.
    push       = (state == StCapt) && sram.vgaResult.done && !line_start;
    fills_fifo = (fifo_count == LastFree) && !pop_ok;
    px_valid   = (fifo_count != '0);
    busy       = (state != StIdle);
  end

  assign sram.vgaRequest = sram_request(state == StReq, cur_addr);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= StIdle;
      cur_addr  <= '0;
      remaining <= '0;
      underflow <= 1'b0;
    end else if (line_start) begin
      cur_addr  <= line_base;
      remaining <= line_words;
      underflow <= 1'b0;
      state     <= (line_words == '0) ? StIdle : StReq;
    end else begin
      if (px_ready && !px_valid) begin
        underflow <= 1'b1;
      end
      unique case (state)
        StIdle: state <= StIdle;
        StWait: begin
          if (fifo_count < FullCount) begin
            state <= StReq;
          end
        end
        StReq:  state <= StCapt;
        StCapt: begin
          if (sram.vgaResult.done) begin
            cur_addr  <= cur_addr + SRAM_ADDR_WIDTH'(1);
            remaining <= remaining - WordsW'(1);
            if (remaining == WordsW'(1)) begin
              state <= StIdle;
            end else if (fills_fifo) begin
              state <= StWait;
            end else begin
              state <= StReq;
            end
          end else begin
            state <= StReq;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (SRAM_DATA_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (line_start),
    .push      (push),
    .push_data (sram.vgaResult.din),
    .pop       (px_ready),
    .pop_data  (px_data),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_vga_text_fetcher.sv
// Self-checking bench: SRAM responder model returning din = address, a negedge
// monitor logging requests and pops, and scenario tasks checked against a line model.
module tb_vga_text_fetcher;
  import vga_text_fetcher_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        line_start = 1'b0;
  logic [17:0] line_base = '0;
  logic [7:0]  line_words = '0;
  logic [15:0] px_data;
  logic        px_valid;
  logic        px_ready = 1'b0;
  logic        busy;
  logic        underflow;

  vga_text_fetcher_if sram_bus ();

  vga_text_fetcher #(
    .DEPTH     (16),
    .MAX_WORDS (128)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .line_start (line_start),
    .line_base  (line_base),
    .line_words (line_words),
    .sram       (sram_bus),
    .px_data    (px_data),
    .px_valid   (px_valid),
    .px_ready   (px_ready),
    .busy       (busy),
    .underflow  (underflow)
  );

  always #10 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] exp_data(input logic [17:0] a);
    return a[15:0];
  endfunction

  // SRAM controller model: answers a read one cycle later, optionally withholding done.
  int   drop_req_id = 0;
  int   drop_done_id = 0;
  logic [17:0] drop_addr = '0;
  logic rand_hold = 1'b0;
  logic ctl_hold;

  always @(posedge clk) begin
    ctl_hold = 1'b0;
    if (!sram_bus.vgaRequest.oe_n) begin
      if (drop_req_id != drop_done_id && sram_bus.vgaRequest.address == drop_addr) begin
        ctl_hold = 1'b1;
        drop_done_id = drop_req_id;
      end else if (rand_hold && $urandom_range(3) == 0) begin
        ctl_hold = 1'b1;
      end
      sram_bus.vgaResult.done <= !ctl_hold;
      sram_bus.vgaResult.din  <= exp_data(sram_bus.vgaRequest.address);
    end else begin
      sram_bus.vgaResult.done <= 1'b0;
      sram_bus.vgaResult.din  <= 16'hDEAD;
    end
  end

  logic [17:0] req_q[$];
  int          req_cyc_q[$];
  logic [15:0] pop_q[$];
  int          pop_cyc_q[$];
  int          fall_q[$];
  logic        busy_prev = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (!sram_bus.vgaRequest.oe_n) begin
        req_q.push_back(sram_bus.vgaRequest.address);
        req_cyc_q.push_back(cyc);
      end
      if (px_valid && px_ready) begin
        pop_q.push_back(px_data);
        pop_cyc_q.push_back(cyc);
      end
      if (busy_prev && !busy) fall_q.push_back(cyc);
    end
    busy_prev = busy;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_line(input logic [17:0] base, input logic [7:0] words, output int c0);
    step(1);
    line_base  = base;
    line_words = words;
    line_start = 1'b1;
    c0         = cyc;
    step(1);
    line_start = 1'b0;
  endtask

  task automatic wait_drained(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step(1);
      if (!busy && !px_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int c0;
    int n0;
    rst_n = 1'b0;
    step(3);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (underflow !== 1'b0) begin miscompares++; $display("FAIL reset_underflow: got %b want 0", underflow); end
    vectors++; if (px_valid !== 1'b0) begin miscompares++; $display("FAIL reset_px_valid: got %b want 0", px_valid); end
    vectors++; if (px_data !== 16'h0) begin miscompares++; $display("FAIL reset_px_data: got %h want 0000", px_data); end
    vectors++;
    if (sram_bus.vgaRequest !== sram_request(1'b0, 18'h0)) begin
      miscompares++;
      $display("FAIL reset_request: got %h want %h", sram_bus.vgaRequest, sram_request(1'b0, 18'h0));
    end
    rst_n = 1'b1;
    // Reset in the middle of a line must discard everything.
    px_ready = 1'b0;
    start_line(18'h03A5, 8'd10, c0);
    step(8);
    vectors++; if (px_valid !== 1'b1) begin miscompares++; $display("FAIL midline_filled: got %b want 1", px_valid); end
    rst_n = 1'b0;
    step(1);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midline_rst_busy: got %b want 0", busy); end
    vectors++; if (px_valid !== 1'b0) begin miscompares++; $display("FAIL midline_rst_valid: got %b want 0", px_valid); end
    vectors++; if (px_data !== 16'h0) begin miscompares++; $display("FAIL midline_rst_data: got %h want 0000", px_data); end
    vectors++;
    if (sram_bus.vgaRequest.address !== 18'h0) begin
      miscompares++;
      $display("FAIL midline_rst_addr: got %h want 00000", sram_bus.vgaRequest.address);
    end
    rst_n = 1'b1;
    n0 = req_q.size();
    step(6);
    vectors++; if (req_q.size() != n0) begin miscompares++; $display("FAIL midline_rst_quiet: got %0d requests want 0", req_q.size() - n0); end
  endtask

  task automatic test_basic();
    int c0, n0, p0, f0;
    bit ok;
    px_ready = 1'b1;
    n0 = req_q.size(); p0 = pop_q.size(); f0 = fall_q.size();
    start_line(18'h100, 8'd4, c0);
    wait_drained(100, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL basic_timeout: got busy=%b want drained", busy); end
    vectors++; if (req_q.size() - n0 != 4) begin miscompares++; $display("FAIL basic_req_count: got %0d want 4", req_q.size() - n0); end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (req_q[n0+i] !== 18'h100 + 18'(i) || req_cyc_q[n0+i] != c0 + 1 + 2 * i) begin
        miscompares++;
        $display("FAIL basic_req%0d: got %h@%0d want %h@%0d", i, req_q[n0+i], req_cyc_q[n0+i],
                 18'h100 + 18'(i), c0 + 1 + 2 * i);
      end
    end
    vectors++; if (pop_q.size() - p0 != 4) begin miscompares++; $display("FAIL basic_pop_count: got %0d want 4", pop_q.size() - p0); end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (pop_q[p0+i] !== exp_data(18'h100 + 18'(i))) begin
        miscompares++;
        $display("FAIL basic_pop%0d: got %h want %h", i, pop_q[p0+i], exp_data(18'h100 + 18'(i)));
      end
    end
    vectors++; if (pop_cyc_q[p0] != c0 + 3) begin miscompares++; $display("FAIL basic_first_valid: got cycle %0d want %0d", pop_cyc_q[p0] - c0, 3); end
    vectors++;
    if (fall_q.size() != f0 + 1 || fall_q[f0] != c0 + 9) begin
      miscompares++;
      $display("FAIL basic_busy_fall: got %0d falls, cycle %0d want 1 fall, cycle 9", fall_q.size() - f0,
               fall_q[f0] - c0);
    end
  endtask

  task automatic test_backpressure();
    int c0, n0, p0;
    bit ok;
    px_ready = 1'b0;
    n0 = req_q.size(); p0 = pop_q.size();
    start_line(18'h040, 8'd20, c0);
    step(60);
    vectors++; if (req_q.size() - n0 != 16) begin miscompares++; $display("FAIL bp_req_count: got %0d want 16", req_q.size() - n0); end
    vectors++; if (sram_bus.vgaRequest.oe_n !== 1'b1 || busy !== 1'b1) begin miscompares++; $display("FAIL bp_wait: got oe_n=%b busy=%b want 1 1", sram_bus.vgaRequest.oe_n, busy); end
    vectors++; if (px_data !== exp_data(18'h040)) begin miscompares++; $display("FAIL bp_head: got %h want %h", px_data, exp_data(18'h040)); end
    px_ready = 1'b1;
    step(1);
    px_ready = 1'b0;
    step(10);
    vectors++; if (req_q.size() - n0 != 17) begin miscompares++; $display("FAIL bp_one_more: got %0d want 17", req_q.size() - n0); end
    px_ready = 1'b1;
    wait_drained(300, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL bp_timeout: got busy=%b want drained", busy); end
    vectors++; if (pop_q.size() - p0 != 20 || req_q.size() - n0 != 20) begin miscompares++; $display("FAIL bp_counts: got %0d pops %0d reqs want 20 20", pop_q.size() - p0, req_q.size() - n0); end
    for (int i = 0; i < 20; i++) begin
      vectors++;
      if (pop_q[p0+i] !== exp_data(18'h040 + 18'(i))) begin
        miscompares++;
        $display("FAIL bp_pop%0d: got %h want %h", i, pop_q[p0+i], exp_data(18'h040 + 18'(i)));
      end
    end
  endtask

  task automatic test_retry();
    int c0, n0, p0;
    bit ok;
    logic [17:0] exp_req [3];
    exp_req[0] = 18'h100; exp_req[1] = 18'h101; exp_req[2] = 18'h101;
    px_ready  = 1'b1;
    drop_addr = 18'h101;
    drop_req_id++;
    n0 = req_q.size(); p0 = pop_q.size();
    start_line(18'h100, 8'd2, c0);
    wait_drained(100, ok);
    vectors++; if (!ok || req_q.size() - n0 != 3) begin miscompares++; $display("FAIL retry_req_count: got %0d want 3", req_q.size() - n0); end
    for (int i = 0; i < 3; i++) begin
      vectors++; if (req_q[n0+i] !== exp_req[i]) begin miscompares++; $display("FAIL retry_req%0d: got %h want %h", i, req_q[n0+i], exp_req[i]); end
    end
    vectors++;
    if (pop_q.size() - p0 != 2 || pop_q[p0] !== 16'h0100 || pop_q[p0+1] !== 16'h0101) begin
      miscompares++;
      $display("FAIL retry_pops: got %0d entries %h %h want 2 entries 0100 0101", pop_q.size() - p0,
               pop_q[p0], pop_q[p0+1]);
    end
  endtask

  task automatic test_restart();
    int c0, c1, n0, p0;
    bit ok;
    px_ready = 1'b0;
    n0 = req_q.size(); p0 = pop_q.size();
    start_line(18'h100, 8'd8, c0);
    for (int i = 0; i < 20; i++) begin
      if (req_q.size() - n0 == 3) break;
      step(1);
    end
    // Now in the capture cycle of the third word.
    line_base = 18'h200; line_words = 8'd3; line_start = 1'b1; c1 = cyc;
    step(1);
    line_start = 1'b0;
    vectors++; if (px_valid !== 1'b0) begin miscompares++; $display("FAIL restart_flush: got px_valid=%b want 0", px_valid); end
    px_ready = 1'b1;
    wait_drained(100, ok);
    vectors++; if (!ok || req_q.size() - n0 != 6) begin miscompares++; $display("FAIL restart_req_count: got %0d want 6", req_q.size() - n0); end
    vectors++;
    if (req_q[n0+3] !== 18'h200 || req_cyc_q[n0+3] != c1 + 1) begin
      miscompares++;
      $display("FAIL restart_first_req: got %h@%0d want 00200@%0d", req_q[n0+3], req_cyc_q[n0+3] - c1, 1);
    end
    vectors++; if (pop_q.size() - p0 != 3) begin miscompares++; $display("FAIL restart_pop_count: got %0d want 3", pop_q.size() - p0); end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (pop_q[p0+i] !== exp_data(18'h200 + 18'(i))) begin
        miscompares++;
        $display("FAIL restart_pop%0d: got %h want %h", i, pop_q[p0+i], exp_data(18'h200 + 18'(i)));
      end
    end
  endtask

  task automatic test_wrap();
    int c0, n0, p0;
    bit ok;
    logic [17:0] a;
    px_ready = 1'b1;
    n0 = req_q.size(); p0 = pop_q.size();
    start_line(18'h3FFFF, 8'd3, c0);
    wait_drained(100, ok);
    vectors++; if (!ok || req_q.size() - n0 != 3 || pop_q.size() - p0 != 3) begin miscompares++; $display("FAIL wrap_counts: got %0d reqs %0d pops want 3 3", req_q.size() - n0, pop_q.size() - p0); end
    for (int i = 0; i < 3; i++) begin
      a = 18'h3FFFF + 18'(i);
      vectors++;
      if (req_q[n0+i] !== a || pop_q[p0+i] !== exp_data(a)) begin
        miscompares++;
        $display("FAIL wrap_word%0d: got addr %h data %h want %h %h", i, req_q[n0+i], pop_q[p0+i], a, exp_data(a));
      end
    end
  endtask

  task automatic test_zero_underflow();
    int c0, n0;
    px_ready = 1'b0;
    n0 = req_q.size();
    start_line(18'h055, 8'd0, c0);
    vectors++; if (underflow !== 1'b0) begin miscompares++; $display("FAIL zero_clears_uf: got %b want 0", underflow); end
    for (int i = 0; i < 5; i++) begin
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL zero_busy%0d: got %b want 0", i, busy); end
      step(1);
    end
    vectors++; if (req_q.size() != n0) begin miscompares++; $display("FAIL zero_no_req: got %0d want 0", req_q.size() - n0); end
    px_ready = 1'b1;
    step(1);
    px_ready = 1'b0;
    vectors++; if (underflow !== 1'b1) begin miscompares++; $display("FAIL uf_set: got %b want 1", underflow); end
    step(5);
    vectors++; if (underflow !== 1'b1 || px_valid !== 1'b0) begin miscompares++; $display("FAIL uf_hold: got uf=%b valid=%b want 1 0", underflow, px_valid); end
    start_line(18'h0, 8'd0, c0);
    vectors++; if (underflow !== 1'b0) begin miscompares++; $display("FAIL uf_clear: got %b want 0", underflow); end
  endtask

  task automatic test_random();
    int c0, p0;
    bit ok;
    logic [17:0] base;
    logic [7:0]  words;
    rand_hold = 1'b1;
    for (int line = 0; line < 6; line++) begin
      base  = 18'($urandom);
      words = 8'($urandom_range(40, 1));
      p0    = pop_q.size();
      px_ready = 1'b0;
      start_line(base, words, c0);
      ok = 1'b0;
      for (int i = 0; i < 1500; i++) begin
        px_ready = ($urandom_range(2) != 0);
        step(1);
        if (!busy && !px_valid) begin
          ok = 1'b1;
          break;
        end
      end
      px_ready = 1'b0;
      vectors++; if (!ok || pop_q.size() - p0 != int'(words)) begin miscompares++; $display("FAIL rand%0d_count: got %0d want %0d", line, pop_q.size() - p0, words); end
      for (int i = 0; i < int'(words); i++) begin
        vectors++;
        if (pop_q[p0+i] !== exp_data(base + 18'(i))) begin
          miscompares++;
          $display("FAIL rand%0d_pop%0d: got %h want %h", line, i, pop_q[p0+i], exp_data(base + 18'(i)));
        end
      end
    end
    rand_hold = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_retry();
    test_restart();
    test_wrap();
    test_zero_underflow();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got no completion want finish");
    $fatal(1);
  end

endmodule
